// File: rtl/ex_wb_sched.sv
// ex_wb_sched
//   Writeback scheduler for the two execute-stage result lanes. ALU results
//   always own their lane. MDU and FPU completions wait in one-entry buffers
//   and take a lane only when the ALU leaves it idle. The FPU may use lane 0
//   only; the MDU prefers lane 1 and falls back to lane 0. When the MDU and
//   the FPU both want lane 0, a round-robin pointer picks the winner. A
//   per-buffer starvation counter raises registered stall requests so that
//   issue can leave a lane idle for a waiting result.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   simd_ena                    1: full DATA_W on wb; 0: bits above 31 zeroed
//   aluK_vld/_data/_rd          ALU result for lane K (K = 0, 1)
//   mdu_vld/_data/_rd/_ready    MDU completion handshake
//   fpu_vld/_data/_rd/_ready    FPU completion handshake
//   wbK_vld/_data/_rd/_src      registered writeback lane K
//                               (src: 0 none, 1 ALU, 2 MDU, 3 FPU)
//   stall_lane0/1               registered request to keep the ALU off a lane
//
// Handshake: a result transfers on a clock edge where xxx_vld & xxx_ready.
// xxx_ready = ~pend | grant, so it is high whenever the buffer is empty or
// is being drained this cycle; the producer may refill in the same cycle the
// old entry leaves. The producer holds vld/data/rd stable until transfer.
// A transferred entry becomes pending at that edge and is never granted
// before the following cycle.
module ex_wb_sched #(
   parameter int DATA_W       = 64,
   parameter int RD_W         = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              simd_ena,
   input  logic              alu0_vld,
   input  logic [DATA_W-1:0] alu0_data,
   input  logic [RD_W-1:0]   alu0_rd,
   input  logic              alu1_vld,
   input  logic [DATA_W-1:0] alu1_data,
   input  logic [RD_W-1:0]   alu1_rd,
   input  logic              mdu_vld,
   input  logic [DATA_W-1:0] mdu_data,
   input  logic [RD_W-1:0]   mdu_rd,
   output logic              mdu_ready,
   input  logic              fpu_vld,
   input  logic [DATA_W-1:0] fpu_data,
   input  logic [RD_W-1:0]   fpu_rd,
   output logic              fpu_ready,
   output logic              wb0_vld,
   output logic [DATA_W-1:0] wb0_data,
   output logic [RD_W-1:0]   wb0_rd,
   output logic [1:0]        wb0_src,
   output logic              wb1_vld,
   output logic [DATA_W-1:0] wb1_data,
   output logic [RD_W-1:0]   wb1_rd,
   output logic [1:0]        wb1_src,
   output logic              stall_lane0,
   output logic              stall_lane1
);

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MDU  = 2'd2,
      SRC_FPU  = 2'd3
   } srcSel_e;

   localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'({32{1'b1}});

   // Buffered completions
   logic              mduPend, fpuPend;
   logic [DATA_W-1:0] mduData, fpuData;
   logic [RD_W-1:0]   mduRd, fpuRd;
   logic [CNT_W-1:0]  mduCnt, fpuCnt;

   // 1: FPU wins the next contested lane-0 grant, 0: MDU wins
   logic              rrFpu;

   logic free0, free1;
   logic grantMdu1, mduWants0, contend;
   logic grantMdu0, grantFpu0, grantMdu, grantFpu;
   logic mduStarve, fpuStarve;

   srcSel_e           lane0Src, lane1Src;
   logic [DATA_W-1:0] lane0Data, lane1Data;
   logic [RD_W-1:0]   lane0Rd, lane1Rd;

   // Grant evaluation. The MDU takes lane 1 first so that lane 0 stays open
   // for the FPU, which cannot use lane 1.
   always_comb begin
      free0     = ~alu0_vld;
      free1     = ~alu1_vld;
      grantMdu1 = mduPend & free1;
      mduWants0 = mduPend & ~grantMdu1;
      contend   = mduWants0 & fpuPend & free0;
      grantMdu0 = free0 & mduWants0 & (~fpuPend | ~rrFpu);
      grantFpu0 = free0 & fpuPend & (~mduWants0 | rrFpu);
      grantMdu  = grantMdu0 | grantMdu1;
      grantFpu  = grantFpu0;
      mduStarve = (mduCnt >= CNT_MAX);
      fpuStarve = (fpuCnt >= CNT_MAX);
   end

   assign mdu_ready = ~mduPend | grantMdu;
   assign fpu_ready = ~fpuPend | grantFpu;

   // Lane source selection: ALU first, then the granted buffer entry.
   always_comb begin
      lane0Src  = SRC_NONE;
      lane0Data = '0;
      lane0Rd   = '0;
      lane1Src  = SRC_NONE;
      lane1Data = '0;
      lane1Rd   = '0;
      if (alu0_vld) begin
         lane0Src  = SRC_ALU;
         lane0Data = alu0_data;
         lane0Rd   = alu0_rd;
      end else if (grantMdu0) begin
         lane0Src  = SRC_MDU;
         lane0Data = mduData;
         lane0Rd   = mduRd;
      end else if (grantFpu0) begin
         lane0Src  = SRC_FPU;
         lane0Data = fpuData;
         lane0Rd   = fpuRd;
      end
      if (alu1_vld) begin
         lane1Src  = SRC_ALU;
         lane1Data = alu1_data;
         lane1Rd   = alu1_rd;
      end else if (grantMdu1) begin
         lane1Src  = SRC_MDU;
         lane1Data = mduData;
         lane1Rd   = mduRd;
      end
      if (!simd_ena) begin
         lane0Data = lane0Data & LOW_MASK;
         lane1Data = lane1Data & LOW_MASK;
      end
   end

   // Buffers: a new entry has priority over the drain, which covers the
   // same-cycle refill case.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mduPend <= 1'b0;
         mduData <= '0;
         mduRd   <= '0;
         fpuPend <= 1'b0;
         fpuData <= '0;
         fpuRd   <= '0;
      end else begin
         if (mdu_vld && mdu_ready) begin
            mduPend <= 1'b1;
            mduData <= mdu_data;
            mduRd   <= mdu_rd;
         end else if (grantMdu) begin
            mduPend <= 1'b0;
         end
         if (fpu_vld && fpu_ready) begin
            fpuPend <= 1'b1;
            fpuData <= fpu_data;
            fpuRd   <= fpu_rd;
         end else if (grantFpu) begin
            fpuPend <= 1'b0;
         end
      end
   end

   // Starvation counters and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mduCnt <= '0;
         fpuCnt <= '0;
         rrFpu  <= 1'b1;
      end else begin
         if (!mduPend || grantMdu) begin
            mduCnt <= '0;
         end else if (!mduStarve) begin
            mduCnt <= mduCnt + CNT_W'(1);
         end
         if (!fpuPend || grantFpu) begin
            fpuCnt <= '0;
         end else if (!fpuStarve) begin
            fpuCnt <= fpuCnt + CNT_W'(1);
         end
         // After a contested grant the loser gets the next contest.
         if (contend) begin
            rrFpu <= ~rrFpu;
         end
      end
   end

   // Registered writeback and stall requests. A starving MDU asks for lane 0
   // too only while the ALU is also holding lane 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb0_vld     <= 1'b0;
         wb0_data    <= '0;
         wb0_rd      <= '0;
         wb0_src     <= SRC_NONE;
         wb1_vld     <= 1'b0;
         wb1_data    <= '0;
         wb1_rd      <= '0;
         wb1_src     <= SRC_NONE;
         stall_lane0 <= 1'b0;
         stall_lane1 <= 1'b0;
      end else begin
         wb0_vld     <= (lane0Src != SRC_NONE);
         wb0_data    <= lane0Data;
         wb0_rd      <= lane0Rd;
         wb0_src     <= lane0Src;
         wb1_vld     <= (lane1Src != SRC_NONE);
         wb1_data    <= lane1Data;
         wb1_rd      <= lane1Rd;
         wb1_src     <= lane1Src;
         stall_lane0 <= fpuStarve | (mduStarve & alu1_vld);
         stall_lane1 <= mduStarve;
      end
   end

endmodule

// File: tb/tb_ex_wb_sched.sv
// tb_ex_wb_sched
//   Directed scenarios for the writeback scheduler followed by a randomized
//   run against a lane-assignment reference model.
module tb_ex_wb_sched;

   localparam int DATA_W = 64;
   localparam int RD_W   = 5;
   localparam int LIMIT  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              simd_ena;
   logic              alu0_vld, alu1_vld;
   logic [DATA_W-1:0] alu0_data, alu1_data;
   logic [RD_W-1:0]   alu0_rd, alu1_rd;
   logic              mdu_vld, fpu_vld;
   logic [DATA_W-1:0] mdu_data, fpu_data;
   logic [RD_W-1:0]   mdu_rd, fpu_rd;
   logic              mdu_ready, fpu_ready;
   logic              wb0_vld, wb1_vld;
   logic [DATA_W-1:0] wb0_data, wb1_data;
   logic [RD_W-1:0]   wb0_rd, wb1_rd;
   logic [1:0]        wb0_src, wb1_src;
   logic              stall_lane0, stall_lane1;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state: index 0 = MDU buffer, index 1 = FPU buffer
   bit                mPend [2];
   logic [DATA_W-1:0] mData [2];
   logic [RD_W-1:0]   mRd   [2];
   int                mWait [2];
   bit                mRrFpu;

   // Model expectations for the cycle just evaluated
   bit                eReady  [2];
   bit                eWbVld  [2];
   logic [DATA_W-1:0] eWbData [2];
   logic [RD_W-1:0]   eWbRd   [2];
   logic [1:0]        eWbSrc  [2];
   bit                eStall  [2];

   logic obsMduReady, obsFpuReady;
   logic [DATA_W-1:0] expQ [$];

   ex_wb_sched #(.DATA_W(DATA_W), .RD_W(RD_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .simd_ena(simd_ena),
      .alu0_vld(alu0_vld), .alu0_data(alu0_data), .alu0_rd(alu0_rd),
      .alu1_vld(alu1_vld), .alu1_data(alu1_data), .alu1_rd(alu1_rd),
      .mdu_vld(mdu_vld), .mdu_data(mdu_data), .mdu_rd(mdu_rd), .mdu_ready(mdu_ready),
      .fpu_vld(fpu_vld), .fpu_data(fpu_data), .fpu_rd(fpu_rd), .fpu_ready(fpu_ready),
      .wb0_vld(wb0_vld), .wb0_data(wb0_data), .wb0_rd(wb0_rd), .wb0_src(wb0_src),
      .wb1_vld(wb1_vld), .wb1_data(wb1_data), .wb1_rd(wb1_rd), .wb1_src(wb1_src),
      .stall_lane0(stall_lane0), .stall_lane1(stall_lane1)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // ---------------- reference model ----------------
   // Assigns owners to the two lanes from the rules: ALU owns its lane, the
   // MDU goes to a free lane 1 else competes for lane 0, the FPU can only
   // use lane 0, and a two-way fight for lane 0 is settled round-robin.
   task automatic modelStep();
      int   lane [2];
      bit   granted [2];
      bit   offered [2];
      logic [DATA_W-1:0] inData [2];
      logic [RD_W-1:0]   inRd [2];
      logic [DATA_W-1:0] d;
      offered[0] = mdu_vld;  inData[0] = mdu_data;  inRd[0] = mdu_rd;
      offered[1] = fpu_vld;  inData[1] = fpu_data;  inRd[1] = fpu_rd;
      lane[0] = alu0_vld ? 1 : 0;
      lane[1] = alu1_vld ? 1 : 0;
      granted[0] = 0;
      granted[1] = 0;
      if (mPend[0] && lane[1] == 0) begin
         lane[1] = 2;
         granted[0] = 1;
      end
      if (lane[0] == 0) begin
         if (mPend[0] && !granted[0] && mPend[1]) begin
            lane[0] = mRrFpu ? 3 : 2;
            mRrFpu  = !mRrFpu;
         end else if (mPend[0] && !granted[0]) begin
            lane[0] = 2;
         end else if (mPend[1]) begin
            lane[0] = 3;
         end
         if (lane[0] == 2) granted[0] = 1;
         if (lane[0] == 3) granted[1] = 1;
      end
      for (int i = 0; i < 2; i++) eReady[i] = !mPend[i] || granted[i];
      eStall[1] = (mWait[0] >= LIMIT);
      eStall[0] = (mWait[1] >= LIMIT) || ((mWait[0] >= LIMIT) && alu1_vld);
      for (int k = 0; k < 2; k++) begin
         eWbSrc[k] = 2'(lane[k]);
         eWbVld[k] = (lane[k] != 0);
         case (lane[k])
            1:       begin d = (k == 0) ? alu0_data : alu1_data; eWbRd[k] = (k == 0) ? alu0_rd : alu1_rd; end
            2:       begin d = mData[0]; eWbRd[k] = mRd[0]; end
            3:       begin d = mData[1]; eWbRd[k] = mRd[1]; end
            default: begin d = '0; eWbRd[k] = '0; end
         endcase
         if (!simd_ena) d[63:32] = '0;
         eWbData[k] = d;
      end
      for (int i = 0; i < 2; i++) begin
         if (mPend[i] && !granted[i]) mWait[i] = (mWait[i] + 1 > LIMIT) ? LIMIT : mWait[i] + 1;
         else mWait[i] = 0;
         if (offered[i] && eReady[i]) begin
            mPend[i] = 1; mData[i] = inData[i]; mRd[i] = inRd[i];
         end else if (granted[i]) begin
            mPend[i] = 0;
         end
      end
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mPend[i] = 0; mWait[i] = 0;
            eWbVld[i] = 0; eWbData[i] = '0; eWbRd[i] = '0; eWbSrc[i] = 2'd0; eStall[i] = 0;
         end
         mRrFpu = 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock: sample the combinational readies before the edge, advance
   // the model, return 1 time unit after the edge with outputs settled.
   task automatic cycle();
      #2;
      obsMduReady = mdu_ready;
      obsFpuReady = fpu_ready;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      rst_n = 1'b1;
      alu0_vld = 1'b0; alu0_data = '0; alu0_rd = '0;
      alu1_vld = 1'b0; alu1_data = '0; alu1_rd = '0;
      mdu_vld  = 1'b0; mdu_data  = '0; mdu_rd  = '0;
      fpu_vld  = 1'b0; fpu_data  = '0; fpu_rd  = '0;
   endtask

   task automatic drain();
      setIdle();
      repeat (3) cycle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      setIdle();
      simd_ena = 1'b1;
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      testsRun++; if (wb0_vld !== 1'b0) begin testsFailed++; $display("FAIL reset_wb0_vld got=%0b want=0", wb0_vld); end
      testsRun++; if (wb1_vld !== 1'b0) begin testsFailed++; $display("FAIL reset_wb1_vld got=%0b want=0", wb1_vld); end
      testsRun++; if (wb0_src !== 2'd0 || wb1_src !== 2'd0) begin testsFailed++; $display("FAIL reset_src got=%0d/%0d want=0/0", wb0_src, wb1_src); end
      testsRun++; if (wb0_data !== '0 || wb1_data !== '0) begin testsFailed++; $display("FAIL reset_data got=%0h/%0h want=0/0", wb0_data, wb1_data); end
      testsRun++; if (stall_lane0 !== 1'b0 || stall_lane1 !== 1'b0) begin testsFailed++; $display("FAIL reset_stall got=%0b/%0b want=0/0", stall_lane0, stall_lane1); end
      #1;
      testsRun++; if (mdu_ready !== 1'b1 || fpu_ready !== 1'b1) begin testsFailed++; $display("FAIL reset_ready got=%0b/%0b want=1/1", mdu_ready, fpu_ready); end
   endtask

   task automatic test_fpu_basic(input logic simd, input logic [DATA_W-1:0] expData);
      setIdle();
      simd_ena = simd;
      fpu_vld  = 1'b1;
      fpu_data = 64'h1234_5678_9ABC_DEF0;
      fpu_rd   = 5'd9;
      cycle();
      testsRun++; if (obsFpuReady !== 1'b1) begin testsFailed++; $display("FAIL fpu_ready got=%0b want=1", obsFpuReady); end
      testsRun++; if (wb0_vld !== 1'b0) begin testsFailed++; $display("FAIL fpu_no_same_cycle_grant got=%0b want=0", wb0_vld); end
      setIdle();
      cycle();
      testsRun++; if (wb0_vld !== 1'b1 || wb0_src !== 2'd3) begin testsFailed++; $display("FAIL fpu_wb0 got vld=%0b src=%0d want vld=1 src=3", wb0_vld, wb0_src); end
      testsRun++; if (wb0_data !== expData) begin testsFailed++; $display("FAIL fpu_wb0_data simd=%0b got=%h want=%h", simd, wb0_data, expData); end
      testsRun++; if (wb0_rd !== 5'd9) begin testsFailed++; $display("FAIL fpu_wb0_rd got=%0d want=9", wb0_rd); end
      testsRun++; if (wb1_vld !== 1'b0) begin testsFailed++; $display("FAIL fpu_wb1_idle got=%0b want=0", wb1_vld); end
   endtask

   task automatic test_starvation();
      logic [DATA_W-1:0] first, second;
      first  = rand64();
      second = rand64();
      setIdle();
      simd_ena  = 1'b1;
      alu0_vld  = 1'b1; alu0_data = rand64(); alu0_rd = 5'd1;
      alu1_vld  = 1'b1; alu1_data = rand64(); alu1_rd = 5'd2;
      mdu_vld   = 1'b1; mdu_data  = first;    mdu_rd  = 5'd3;
      cycle();
      testsRun++; if (obsMduReady !== 1'b1) begin testsFailed++; $display("FAIL starve_first_accept got=%0b want=1", obsMduReady); end
      mdu_data = second;
      mdu_rd   = 5'd4;
      for (int c = 1; c <= 6; c++) begin
         cycle();
         testsRun++; if (obsMduReady !== 1'b0) begin testsFailed++; $display("FAIL starve_ready_held c=%0d got=%0b want=0", c, obsMduReady); end
         testsRun++; if (stall_lane1 !== (c >= 5)) begin testsFailed++; $display("FAIL starve_stall1 c=%0d got=%0b want=%0b", c, stall_lane1, c >= 5); end
         testsRun++; if (stall_lane0 !== (c >= 5)) begin testsFailed++; $display("FAIL starve_stall0 c=%0d got=%0b want=%0b", c, stall_lane0, c >= 5); end
         testsRun++; if (wb1_src !== 2'd1) begin testsFailed++; $display("FAIL starve_alu_keeps_lane c=%0d got=%0d want=1", c, wb1_src); end
      end
      alu1_vld = 1'b0;
      cycle();
      testsRun++; if (obsMduReady !== 1'b1) begin testsFailed++; $display("FAIL starve_refill_ready got=%0b want=1", obsMduReady); end
      testsRun++; if (wb1_src !== 2'd2 || wb1_data !== first) begin testsFailed++; $display("FAIL starve_drain got src=%0d data=%h want src=2 data=%h", wb1_src, wb1_data, first); end
      testsRun++; if (stall_lane1 !== 1'b1) begin testsFailed++; $display("FAIL starve_stall1_hold got=%0b want=1", stall_lane1); end
      testsRun++; if (stall_lane0 !== 1'b0) begin testsFailed++; $display("FAIL starve_stall0_drop got=%0b want=0", stall_lane0); end
      mdu_vld = 1'b0;
      cycle();
      testsRun++; if (stall_lane1 !== 1'b0) begin testsFailed++; $display("FAIL starve_stall1_clear got=%0b want=0", stall_lane1); end
      testsRun++; if (wb1_src !== 2'd2 || wb1_data !== second || wb1_rd !== 5'd4) begin testsFailed++; $display("FAIL starve_second got src=%0d data=%h rd=%0d want src=2 data=%h rd=4", wb1_src, wb1_data, wb1_rd, second); end
      drain();
   endtask

   task automatic test_contention();
      logic [DATA_W-1:0] mduQ [$];
      logic [DATA_W-1:0] fpuQ [$];
      logic [DATA_W-1:0] exp;
      bit fpuTurn;
      setIdle();
      simd_ena = 1'b1;
      alu0_vld = 1'b1; alu0_data = rand64();
      alu1_vld = 1'b1; alu1_data = rand64();
      mdu_vld  = 1'b1; mdu_data  = rand64(); mdu_rd = 5'd10;
      fpu_vld  = 1'b1; fpu_data  = rand64(); fpu_rd = 5'd20;
      cycle();
      mduQ.push_back(mdu_data); mdu_data = rand64();
      fpuQ.push_back(fpu_data); fpu_data = rand64();
      alu0_vld = 1'b0;
      for (int c = 0; c < 5; c++) begin
         fpuTurn = (c % 2 == 0);
         cycle();
         testsRun++; if (obsFpuReady !== fpuTurn || obsMduReady !== !fpuTurn) begin testsFailed++; $display("FAIL contend_ready c=%0d got mdu=%0b fpu=%0b want mdu=%0b fpu=%0b", c, obsMduReady, obsFpuReady, !fpuTurn, fpuTurn); end
         if (fpuTurn) begin
            exp = fpuQ.pop_front();
            fpuQ.push_back(fpu_data); fpu_data = rand64();
         end else begin
            exp = mduQ.pop_front();
            mduQ.push_back(mdu_data); mdu_data = rand64();
         end
         testsRun++; if (wb0_src !== (fpuTurn ? 2'd3 : 2'd2) || wb0_data !== exp) begin testsFailed++; $display("FAIL contend_winner c=%0d got src=%0d data=%h want src=%0d data=%h", c, wb0_src, wb0_data, fpuTurn ? 3 : 2, exp); end
      end
      drain();
   endtask

   task automatic test_back_to_back();
      setIdle();
      simd_ena = 1'b1;
      expQ.delete();
      mdu_vld  = 1'b1; mdu_data = rand64(); mdu_rd = 5'd7;
      cycle();
      expQ.push_back(mdu_data);
      testsRun++; if (obsMduReady !== 1'b1) begin testsFailed++; $display("FAIL b2b_first_ready got=%0b want=1", obsMduReady); end
      testsRun++; if (wb1_vld !== 1'b0) begin testsFailed++; $display("FAIL b2b_no_early_wb got=%0b want=0", wb1_vld); end
      for (int c = 0; c < 3; c++) begin
         if (c < 2) mdu_data = rand64();
         else mdu_vld = 1'b0;
         cycle();
         if (c < 2) begin
            testsRun++; if (obsMduReady !== 1'b1) begin testsFailed++; $display("FAIL b2b_refill_ready c=%0d got=%0b want=1", c, obsMduReady); end
            expQ.push_back(mdu_data);
         end
         testsRun++; if (wb1_vld !== 1'b1 || wb1_src !== 2'd2 || wb1_data !== expQ[0]) begin testsFailed++; $display("FAIL b2b_wb1 c=%0d got vld=%0b src=%0d data=%h want vld=1 src=2 data=%h", c, wb1_vld, wb1_src, wb1_data, expQ[0]); end
         void'(expQ.pop_front());
         testsRun++; if (wb0_vld !== 1'b0) begin testsFailed++; $display("FAIL b2b_lane0_idle c=%0d got=%0b want=0", c, wb0_vld); end
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      setIdle();
      simd_ena = 1'b1;
      alu0_vld = 1'b1; alu0_data = rand64();
      alu1_vld = 1'b1; alu1_data = rand64();
      mdu_vld  = 1'b1; mdu_data  = rand64();
      fpu_vld  = 1'b1; fpu_data  = rand64();
      cycle();
      mdu_vld = 1'b0;
      fpu_vld = 1'b0;
      repeat (5) cycle();
      testsRun++; if (stall_lane0 !== 1'b1) begin testsFailed++; $display("FAIL midrst_stall0_setup got=%0b want=1", stall_lane0); end
      rst_n = 1'b0;
      cycle();
      testsRun++; if (wb0_vld !== 1'b0 || wb1_vld !== 1'b0 || wb0_src !== 2'd0 || wb1_src !== 2'd0) begin testsFailed++; $display("FAIL midrst_wb got vld=%0b/%0b src=%0d/%0d want 0", wb0_vld, wb1_vld, wb0_src, wb1_src); end
      testsRun++; if (wb0_data !== '0 || wb1_data !== '0 || wb0_rd !== '0 || wb1_rd !== '0) begin testsFailed++; $display("FAIL midrst_data got=%h/%h want=0", wb0_data, wb1_data); end
      testsRun++; if (stall_lane0 !== 1'b0 || stall_lane1 !== 1'b0) begin testsFailed++; $display("FAIL midrst_stall got=%0b/%0b want=0/0", stall_lane0, stall_lane1); end
      setIdle();
      for (int c = 0; c < 3; c++) begin
         cycle();
         testsRun++; if (wb0_vld !== 1'b0 || wb1_vld !== 1'b0) begin testsFailed++; $display("FAIL midrst_discard c=%0d got=%0b/%0b want=0/0", c, wb0_vld, wb1_vld); end
      end
      alu0_vld = 1'b1; alu1_vld = 1'b1;
      mdu_vld  = 1'b1; mdu_data = rand64();
      fpu_vld  = 1'b1; fpu_data = rand64();
      cycle();
      alu0_vld = 1'b0;
      mdu_vld  = 1'b0;
      fpu_vld  = 1'b0;
      cycle();
      testsRun++; if (wb0_src !== 2'd3) begin testsFailed++; $display("FAIL midrst_rr_fpu got=%0d want=3", wb0_src); end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         simd_ena  = 1'($urandom_range(0, 1));
         alu0_vld  = ($urandom_range(0, 9) < 6);
         alu1_vld  = ($urandom_range(0, 9) < 7);
         alu0_data = rand64(); alu0_rd = 5'($urandom);
         alu1_data = rand64(); alu1_rd = 5'($urandom);
         mdu_vld   = 1'($urandom_range(0, 1));
         fpu_vld   = 1'($urandom_range(0, 1));
         mdu_data  = rand64(); mdu_rd = 5'($urandom);
         fpu_data  = rand64(); fpu_rd = 5'($urandom);
         cycle();
         testsRun++; if (obsMduReady !== eReady[0] || obsFpuReady !== eReady[1]) begin testsFailed++; $display("FAIL rnd_ready c=%0d got=%0b/%0b want=%0b/%0b", c, obsMduReady, obsFpuReady, eReady[0], eReady[1]); end
         testsRun++; if (wb0_vld !== eWbVld[0] || wb0_src !== eWbSrc[0]) begin testsFailed++; $display("FAIL rnd_wb0_ctl c=%0d got vld=%0b src=%0d want vld=%0b src=%0d", c, wb0_vld, wb0_src, eWbVld[0], eWbSrc[0]); end
         testsRun++; if (wb0_data !== eWbData[0] || wb0_rd !== eWbRd[0]) begin testsFailed++; $display("FAIL rnd_wb0_data c=%0d got=%h/%0d want=%h/%0d", c, wb0_data, wb0_rd, eWbData[0], eWbRd[0]); end
         testsRun++; if (wb1_vld !== eWbVld[1] || wb1_src !== eWbSrc[1]) begin testsFailed++; $display("FAIL rnd_wb1_ctl c=%0d got vld=%0b src=%0d want vld=%0b src=%0d", c, wb1_vld, wb1_src, eWbVld[1], eWbSrc[1]); end
         testsRun++; if (wb1_data !== eWbData[1] || wb1_rd !== eWbRd[1]) begin testsFailed++; $display("FAIL rnd_wb1_data c=%0d got=%h/%0d want=%h/%0d", c, wb1_data, wb1_rd, eWbData[1], eWbRd[1]); end
         testsRun++; if (stall_lane0 !== eStall[0] || stall_lane1 !== eStall[1]) begin testsFailed++; $display("FAIL rnd_stall c=%0d got=%0b/%0b want=%0b/%0b", c, stall_lane0, stall_lane1, eStall[0], eStall[1]); end
      end
      drain();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      setIdle();
      simd_ena = 1'b1;
      test_reset();
      test_fpu_basic(1'b1, 64'h1234_5678_9ABC_DEF0);
      test_fpu_basic(1'b0, 64'h0000_0000_9ABC_DEF0);
      test_starvation();
      test_contention();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ex_wb_sched.md
Name: ex_wb_sched

Overview:
- Schedules the two execute-stage writeback lanes among three kinds of source: single-cycle ALU results, the multiply/divide unit (MDU) and the FPU.
- ALU results own their lane unconditionally. MDU and FPU completions are held in one-entry buffers and use a lane only when the ALU leaves it idle.
- FPU results may use lane 0 only. MDU results may use either lane.
- A starvation counter asks issue to leave a lane idle so that a held result can drain.
- Outputs are registered, with 32-bit zero-extension in non-SIMD mode.

Parameters:
- DATA_W, 64, result data width (must be at least 32).
- RD_W, 5, destination register tag width.
- STARVE_LIMIT, 4, number of cycles a buffered entry may wait before a stall request is raised (must be at least 1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- simd_ena  in  1  1: pass full DATA_W; 0: zero bits [DATA_W-1:32] on outputs.
- alu0_vld / alu1_vld  in  1  ALU result valid on lane 0 / lane 1.
- alu0_data / alu1_data  in  DATA_W  ALU result data.
- alu0_rd / alu1_rd  in  RD_W  ALU destination tag.
- mdu_vld  in  1  MDU result offered.
- mdu_data  in  DATA_W  MDU result data.
- mdu_rd  in  RD_W  MDU destination tag.
- mdu_ready  out  1  MDU result accepted this cycle when mdu_vld=1.
- fpu_vld  in  1  FPU result offered.
- fpu_data  in  DATA_W  FPU result data.
- fpu_rd  in  RD_W  FPU destination tag.
- fpu_ready  out  1  FPU result accepted this cycle when fpu_vld=1.
- wb0_vld / wb1_vld  out  1  writeback lane valid.
- wb0_data / wb1_data  out  DATA_W  writeback data.
- wb0_rd / wb1_rd  out  RD_W  writeback tag.
- wb0_src / wb1_src  out  2  source of the lane: 0 none, 1 ALU, 2 MDU, 3 FPU.
- stall_lane0 / stall_lane1  out  1  request that issue keep the ALU off this lane next cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All wb* outputs and stall_* are 0.
  - Both buffers are emptied; contents are discarded even if a grant was in progress.
  - Both starvation counters are 0.
  - The round-robin pointer is set to FPU.
- Buffers:
  - Each buffer (mdu, fpu) holds {pend, data, rd}.
  - xxx_ready = ~pend | grant_xxx. This is combinational, so the MDU or FPU may refill the buffer in the same cycle it drains.
  - Acceptance happens when vld & ready. The entry becomes pend at the next edge.
  - An entry is never granted in the cycle it is accepted.
- Lane free: free0 = ~alu0_vld, free1 = ~alu1_vld.
- Grant, evaluated each cycle from the current pend flags:
  - The MDU is granted lane 1 if mdu.pend & free1.
  - Otherwise, when mdu.pend & fpu.pend & free0, the MDU and FPU contend for lane 0. The winner is given by the rr pointer. After a contested grant, the pointer flips to the loser.
  - An uncontested grant of lane 0 goes to whichever of mdu.pend or fpu.pend is set.
  - The FPU is never granted lane 1.
  - The MDU and FPU are never both placed on the same lane.
- Output register, updated at the edge following evaluation:
  - Lane k takes the ALU value if alu_k_vld; otherwise the granted buffer entry; otherwise wbk_vld=0 with data/rd/src zeroed.
  - src is set to match the chosen source.
  - Data is zero-extended above bit 31 when simd_ena=0, using simd_ena as sampled in the evaluation cycle.
- Latency:
  - ALU: 1 cycle from input to wb.
  - MDU/FPU: at least 2 cycles from acceptance to wb.
- Starvation:
  - Each buffer's counter increments every cycle that the entry is pend and not granted, and saturates at STARVE_LIMIT.
  - The counter clears on grant or when the buffer is empty.
- Stall requests:
  - stall_lane0 is a registered output. It is 1 when the FPU counter is at or above STARVE_LIMIT, or when the MDU counter is at or above STARVE_LIMIT and lane 1 was also occupied.
  - stall_lane1 is a registered output. It is 1 when the MDU counter is at or above STARVE_LIMIT.
  - The stall signals drop the cycle after the starving entry is granted.
- An ALU valid on a stalled lane still wins the lane. The starving counter stays saturated; this is not an error.

Test Plan:
- Idle ALU, fpu_vld=1 with data 0x1234_5678_9ABC_DEF0, simd_ena=1 -> fpu_ready=1; two cycles later wb0_vld=1, wb0_src=3, wb0_data=0x123456789ABCDEF0; wb1_vld=0.
- Same stimulus with simd_ena=0 -> wb0_data=0x0000_0000_9ABC_DEF0.
- alu0_vld=alu1_vld=1 for 6 cycles while the MDU buffer is pend, STARVE_LIMIT=4:
  - stall_lane1 asserts after 5 cycles.
  - mdu_ready=0 while a second result is offered.
  - Once alu1_vld drops, wb1_src=2 and stall_lane1 clears one cycle later.
- MDU and FPU both pend, alu1_vld=1, alu0 idle:
  - The FPU wins lane 0 first.
  - The next contended cycle grants the MDU.
  - The pointer alternates for at least 4 contentions.
- MDU pend with ALU lanes idle, new mdu_vld in the same cycle:
  - mdu_ready=1.
  - Back-to-back results appear on wb1 in consecutive cycles.
- rst_n=0 for one cycle while both buffers are pend and stall_lane0=1:
  - Next cycle all outputs are 0.
  - No buffered result is ever written back.
  - The rr pointer is FPU.
